// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA video RAM arbiter.
package cga_pkg;

  localparam int unsigned VRAM_ADDR_BITS   = 14;
  localparam logic [4:0]  RAM_PAGE_DEFAULT = 5'd0;

  typedef enum logic [2:0] {
    StIdle,
    StVAddr,
    StVLatch,
    StCAddr,
    StCRd,
    StCWe,
    StCHold
  } arb_state_e;

endpackage

// File: rtl/cga_req_latch.sv
// One-entry request holding register with pending flag and sticky overrun detection.
module cga_req_latch #(
  parameter int unsigned WIDTH   = 8,
  parameter bit          REPLACE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             req,
  input  logic [WIDTH-1:0] data,
  input  logic             clr,
  output logic             take,
  output logic             pend,
  output logic [WIDTH-1:0] held,
  output logic             overrun
);

  logic             pend_q;
  logic             overrun_q;
  logic [WIDTH-1:0] held_q;

  // A request landing in the completion cycle is a fresh request, not a collision.
  assign take    = req & (REPLACE | ~pend_q | clr);
  assign pend    = pend_q;
  assign held    = held_q;
  assign overrun = overrun_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      held_q    <= '0;
    end else begin
      pend_q <= req | (pend_q & ~clr);
      if (take) begin
        held_q <= data;
      end
      if (req & pend_q & ~clr) begin
        overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cga_vram_arbiter.sv
// Arbitrates the single 8-bit video SRAM between CRTC fetches (fixed priority) and
// ISA CPU accesses; all SRAM pins and requester outputs are registered.
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter int unsigned ADDR_BITS = VRAM_ADDR_BITS,
  parameter logic [4:0]  RAM_PAGE  = RAM_PAGE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 vid_req,
  input  logic [ADDR_BITS-1:0] vid_addr,
  output logic [7:0]           vid_data,
  output logic                 vid_valid,
  output logic                 vid_overrun,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [7:0]           cpu_wdata,
  output logic [7:0]           cpu_rdata,
  output logic                 cpu_rdy,
  output logic [18:0]          ram_a,
  output logic [7:0]           ram_dout,
  output logic                 ram_doe,
  input  logic [7:0]           ram_din,
  output logic                 ram_we_l
);

  localparam int unsigned CPU_BITS = ADDR_BITS + 9;

  function automatic logic [18:0] page_addr(input logic [ADDR_BITS-1:0] a);
    return (19'(RAM_PAGE) << ADDR_BITS) | 19'(a);
  endfunction

  arb_state_e state_q, state_d;

  logic [18:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_doe_q, ram_doe_d;
  logic        ram_we_l_q, ram_we_l_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic        vid_valid_q, vid_valid_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        cpu_rdy_q, cpu_rdy_d;

  logic                 vid_clr, vid_pend, vid_take_unused;
  logic [ADDR_BITS-1:0] vid_held;
  logic                 cpu_clr, cpu_pend, cpu_take, cpu_overrun_unused;
  logic [CPU_BITS-1:0]  cpu_held;

  cga_req_latch #(
    .WIDTH  (ADDR_BITS),
    .REPLACE(1'b1)
  ) u_vid_latch (
    .clk    (clk),
    .reset_l(reset_l),
    .req    (vid_req),
    .data   (vid_addr),
    .clr    (vid_clr),
    .take   (vid_take_unused),
    .pend   (vid_pend),
    .held   (vid_held),
    .overrun(vid_overrun)
  );

  cga_req_latch #(
    .WIDTH  (CPU_BITS),
    .REPLACE(1'b0)
  ) u_cpu_latch (
    .clk    (clk),
    .reset_l(reset_l),
    .req    (cpu_req),
    .data   ({cpu_we, cpu_addr, cpu_wdata}),
    .clr    (cpu_clr),
    .take   (cpu_take),
    .pend   (cpu_pend),
    .held   (cpu_held),
    .overrun(cpu_overrun_unused)
  );

  // Effective request fields: a strobe this cycle bypasses the holding register.
  logic [ADDR_BITS-1:0] vaddr_eff;
  logic                 cwe_eff;
  logic [ADDR_BITS-1:0] caddr_eff;
  logic [7:0]           cwdata_eff;
  logic                 vid_any, cpu_any;

  assign vaddr_eff = vid_req ? vid_addr : vid_held;
  assign {cwe_eff, caddr_eff, cwdata_eff} =
      cpu_take ? {cpu_we, cpu_addr, cpu_wdata} : cpu_held;
  assign vid_any = vid_pend | vid_req;
  assign cpu_any = cpu_pend | cpu_req;

  always_comb begin
    state_d     = state_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_doe_d   = 1'b0;
    ram_we_l_d  = 1'b1;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_rdy_d   = cpu_rdy_q;
    vid_clr     = 1'b0;
    cpu_clr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (vid_any) begin
          state_d = StVAddr;
        end else if (cpu_any) begin
          state_d = StCAddr;
        end
      end
      // A second strobe here re-presents the newer address instead of fetching a stale one.
      StVAddr: state_d = vid_req ? StVAddr : StVLatch;
      StVLatch: begin
        vid_data_d  = ram_din;
        vid_valid_d = 1'b1;
        vid_clr     = 1'b1;
        if (vid_req) begin
          state_d = StVAddr;
        end else if (cpu_any) begin
          state_d = StCAddr;
        end else begin
          state_d = StIdle;
        end
      end
      StCAddr: state_d = cpu_held[CPU_BITS-1] ? StCWe : StCRd;
      StCRd: begin
        cpu_rdata_d = ram_din;
        cpu_clr     = 1'b1;
        cpu_rdy_d   = 1'b1;
        state_d     = vid_any ? StVAddr : StIdle;
      end
      StCWe: state_d = StCHold;
      StCHold: begin
        cpu_clr   = 1'b1;
        cpu_rdy_d = 1'b1;
        state_d   = vid_any ? StVAddr : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Pin values are loaded on entry so they are valid throughout the state.
    unique case (state_d)
      StVAddr: ram_a_d = page_addr(vaddr_eff);
      StCAddr: begin
        ram_a_d = page_addr(caddr_eff);
        if (cwe_eff) begin
          ram_dout_d = cwdata_eff;
          ram_doe_d  = 1'b1;
        end
      end
      StCWe: begin
        ram_we_l_d = 1'b0;
        ram_doe_d  = 1'b1;
      end
      StCHold: ram_doe_d = 1'b1;
      default: ;
    endcase

    if (cpu_take) begin
      cpu_rdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= StIdle;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_doe_q   <= 1'b0;
      ram_we_l_q  <= 1'b1;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_rdy_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_doe_q   <= ram_doe_d;
      ram_we_l_q  <= ram_we_l_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_rdy_q   <= cpu_rdy_d;
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_doe   = ram_doe_q;
  assign ram_we_l  = ram_we_l_q;
  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_rdy   = cpu_rdy_q;

endmodule
